// File: rtl/dp_data_ram.sv
// Dual-port synchronous RAM: port A read/write with byte strobes, port B read-only,
// valid/ready requests and RD_LAT-cycle registered read responses.
// Define DP_RAM_CLEAR_EN to zero every word after reset before accepting requests.
module dp_data_ram #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1 << ADDR_WIDTH,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_req_valid,
  output logic                    a_req_ready,
  input  logic                    a_we,
  input  logic [DATA_WIDTH/8-1:0] a_wstrb,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic                    a_resp_valid,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  input  logic                    b_req_valid,
  output logic                    b_req_ready,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  output logic                    b_resp_valid,
  output logic [DATA_WIDTH-1:0]   b_rdata
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

`ifdef DP_RAM_CLEAR_EN
  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_IDLE} state_e;
`else
  typedef enum logic {ST_RESET, ST_IDLE} state_e;
`endif

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_acc, a_in, a_wr, a_rd, b_acc, b_in;
  logic [IDX_W-1:0]      a_idx, b_idx;
  logic [DATA_WIDTH-1:0] a_word, b_word;

  logic [RD_LAT-1:0]     a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [DATA_WIDTH-1:0] a_dat_q [RD_LAT];
  logic [DATA_WIDTH-1:0] a_dat_d [RD_LAT];
  logic [DATA_WIDTH-1:0] b_dat_q [RD_LAT];
  logic [DATA_WIDTH-1:0] b_dat_d [RD_LAT];

`ifdef DP_RAM_CLEAR_EN
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             clr_we;
`endif

  assign a_req_ready  = (state_q == ST_IDLE);
  assign b_req_ready  = (state_q == ST_IDLE);
  assign a_resp_valid = a_vld_q[RD_LAT-1];
  assign a_rdata      = a_dat_q[RD_LAT-1];
  assign b_resp_valid = b_vld_q[RD_LAT-1];
  assign b_rdata      = b_dat_q[RD_LAT-1];

  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = ST_RESET;
    end else begin
      case (state_q)
`ifdef DP_RAM_CLEAR_EN
        ST_RESET: state_d = ST_CLEAR;
        ST_CLEAR: if (clr_cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
`else
        ST_RESET: state_d = ST_IDLE;
`endif
        ST_IDLE:  state_d = ST_IDLE;
        default:  state_d = ST_RESET;
      endcase
    end
  end

`ifdef DP_RAM_CLEAR_EN
  always_comb begin
    clr_we    = (state_q == ST_CLEAR) && !reset;
    clr_cnt_d = '0;
    if (clr_we) clr_cnt_d = clr_cnt_q + 1'b1;
  end
`endif

  // Requests are never taken while reset is high, even if ready is still up this cycle.
  always_comb begin
    a_acc  = a_req_valid & a_req_ready & ~reset;
    a_in   = {1'b0, a_addr} < DEPTH_W;
    a_idx  = a_addr[IDX_W-1:0];
    a_wr   = a_acc & a_we & a_in;
    a_rd   = a_acc & ~a_we;
    a_word = a_in ? mem[a_idx] : '0;
    b_acc  = b_req_valid & b_req_ready & ~reset;
    b_in   = {1'b0, b_addr} < DEPTH_W;
    b_idx  = b_addr[IDX_W-1:0];
    b_word = b_in ? mem[b_idx] : '0;
  end

  // Data stages only advance behind a valid so rdata holds between responses.
  always_comb begin
    a_vld_d    = '0;
    b_vld_d    = '0;
    a_dat_d    = a_dat_q;
    b_dat_d    = b_dat_q;
    a_vld_d[0] = a_rd;
    b_vld_d[0] = b_acc;
    if (a_rd)  a_dat_d[0] = a_word;
    if (b_acc) b_dat_d[0] = b_word;
    for (int unsigned k = 1; k < RD_LAT; k++) begin
      a_vld_d[k] = a_vld_q[k-1];
      b_vld_d[k] = b_vld_q[k-1];
      if (a_vld_q[k-1]) a_dat_d[k] = a_dat_q[k-1];
      if (b_vld_q[k-1]) b_dat_d[k] = b_dat_q[k-1];
    end
    if (reset) begin
      a_vld_d = '0;
      b_vld_d = '0;
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        a_dat_d[k] = '0;
        b_dat_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    a_vld_q <= a_vld_d;
    b_vld_q <= b_vld_d;
    a_dat_q <= a_dat_d;
    b_dat_q <= b_dat_d;
`ifdef DP_RAM_CLEAR_EN
    clr_cnt_q <= clr_cnt_d;
`endif
  end

  // Reads above sample the array before these updates land: read-before-write.
  always_ff @(posedge clk) begin
    if (a_wr) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (a_wstrb[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
`ifdef DP_RAM_CLEAR_EN
    if (clr_we) mem[clr_cnt_q] <= '0;
`endif
  end

endmodule

// File: tb/tb_dp_data_ram.sv
// Self-checking bench for dp_data_ram: reference memory model plus per-port
// response scoreboards checked for data and exact response cycle.
module tb_dp_data_ram;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int LAT = 3;

  logic          clk, reset;
  logic          a_req_valid, a_req_ready, a_we, a_resp_valid;
  logic [3:0]    a_wstrb;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, a_rdata, b_rdata;
  logic          b_req_valid, b_req_ready, b_resp_valid;

  dp_data_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_we(a_we),
    .a_wstrb(a_wstrb), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_resp_valid(a_resp_valid), .a_rdata(a_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_addr(b_addr),
    .b_resp_valid(b_resp_valid), .b_rdata(b_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [DW-1:0] data; } exp_t;
  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] model [DEP];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  function automatic logic [DW-1:0] mrd(input logic [AW-1:0] ad);
    if (int'(ad) < DEP) return model[ad[3:0]];
    return '0;
  endfunction

  // Reads see the model before this edge's write lands.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (reset) begin
      qa.delete();
      qb.delete();
`ifdef DP_RAM_CLEAR_EN
      for (int i = 0; i < DEP; i++) model[i] = '0;
`endif
    end else begin
      if (a_req_valid && a_req_ready && !a_we) begin
        e.due = cyc + LAT - 1; e.data = mrd(a_addr); qa.push_back(e);
      end
      if (b_req_valid && b_req_ready) begin
        e.due = cyc + LAT - 1; e.data = mrd(b_addr); qb.push_back(e);
      end
      if (a_req_valid && a_req_ready && a_we && int'(a_addr) < DEP)
        for (int i = 0; i < 4; i++)
          if (a_wstrb[i]) model[a_addr[3:0]][8*i +: 8] = a_wdata[8*i +: 8];
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (a_resp_valid) begin
      total++;
      if (qa.size() == 0) begin
        bad++; $display("FAIL a_resp_unexpected: got a_resp_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = qa.pop_front();
        if (e.due != cyc || a_rdata !== e.data) begin
          bad++; $display("FAIL a_resp: got %h at cycle %0d, required %h at cycle %0d", a_rdata, cyc, e.data, e.due);
        end
      end
    end else if (qa.size() > 0 && qa[0].due <= cyc) begin
      total++; bad++; e = qa.pop_front();
      $display("FAIL a_resp_missing: got a_resp_valid=0 at cycle %0d, required 1 with %h", cyc, e.data);
    end
    if (b_resp_valid) begin
      total++;
      if (qb.size() == 0) begin
        bad++; $display("FAIL b_resp_unexpected: got b_resp_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = qb.pop_front();
        if (e.due != cyc || b_rdata !== e.data) begin
          bad++; $display("FAIL b_resp: got %h at cycle %0d, required %h at cycle %0d", b_rdata, cyc, e.data, e.due);
        end
      end
    end else if (qb.size() > 0 && qb[0].due <= cyc) begin
      total++; bad++; e = qb.pop_front();
      $display("FAIL b_resp_missing: got b_resp_valid=0 at cycle %0d, required 1 with %h", cyc, e.data);
    end
  end

  task automatic idle();
    a_req_valid = 0; a_we = 0; a_wstrb = '0; a_addr = '0; a_wdata = '0;
    b_req_valid = 0; b_addr = '0;
  endtask

  task automatic a_write(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [3:0] s);
    a_req_valid = 1; a_we = 1; a_addr = ad; a_wdata = d; a_wstrb = s;
    @(negedge clk); idle();
  endtask

  task automatic a_read(input logic [AW-1:0] ad);
    a_req_valid = 1; a_we = 0; a_addr = ad;
    @(negedge clk); idle();
  endtask

  task automatic b_read(input logic [AW-1:0] ad);
    b_req_valid = 1; b_addr = ad;
    @(negedge clk); idle();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
    total++;
    if (qa.size() > 0 || qb.size() > 0) begin
      bad++; $display("FAIL drain: got %0d/%0d responses outstanding, required 0", qa.size(), qb.size());
    end
  endtask

  // Returns the number of sampled cycles ready stayed low after reset release.
  task automatic release_and_count(output int n);
    reset = 0; n = 0;
    @(negedge clk);
    while (!a_req_ready && n < 100) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset();
    int n;
    reset = 1; idle();
    repeat (3) @(negedge clk);
    total++;
    if ({a_req_ready, b_req_ready, a_resp_valid, b_resp_valid, a_rdata, b_rdata} !== '0) begin
      bad++; $display("FAIL reset_values: got rdy=%b%b vld=%b%b a=%h b=%h, required all 0",
        a_req_ready, b_req_ready, a_resp_valid, b_resp_valid, a_rdata, b_rdata);
    end
    release_and_count(n);
`ifdef DP_RAM_CLEAR_EN
    total++;
    if (n != DEP) begin bad++; $display("FAIL clear_ready_low: got %0d cycles, required %0d", n, DEP); end
`else
    total++;
    if (n != 0) begin bad++; $display("FAIL ready_after_reset: got %0d low cycles, required 0", n); end
`endif
    total++;
    if (b_req_ready !== 1'b1) begin bad++; $display("FAIL b_ready_after_reset: got %b, required 1", b_req_ready); end
  endtask

  task automatic test_write_read();
    a_write(5'd3, 32'hDEADBEEF, 4'hF);
    a_read(5'd3);
    drain();
    repeat (3) begin
      @(negedge clk);
      total++;
      if (a_resp_valid !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin
        bad++; $display("FAIL rdata_hold: got vld=%b %h, required vld=0 deadbeef", a_resp_valid, a_rdata);
      end
    end
  endtask

  task automatic test_byte_strobe();
    int n;
    a_write(5'd3, 32'h11223344, 4'h5);
    b_read(5'd3);
    for (n = 0; n < 10 && !b_resp_valid; n++) @(negedge clk);
    total++;
    if (b_rdata !== 32'hDE22BE44) begin bad++; $display("FAIL byte_strobe: got %h, required de22be44", b_rdata); end
    drain();
    a_write(5'd3, 32'hFFFFFFFF, 4'h0);
    a_read(5'd3);
    drain();
    total++;
    if (a_rdata !== 32'hDE22BE44) begin bad++; $display("FAIL zero_strobe: got %h, required de22be44", a_rdata); end
  endtask

  task automatic test_collision();
    a_write(5'd5, 32'hA, 4'hF);
    a_req_valid = 1; a_we = 1; a_addr = 5'd5; a_wdata = 32'hB; a_wstrb = 4'hF;
    b_req_valid = 1; b_addr = 5'd5;
    @(negedge clk);
    idle(); b_req_valid = 1; b_addr = 5'd5;
    @(negedge clk);
    idle();
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      a_req_valid = 1; a_we = 1; a_wstrb = 4'hF; a_addr = AW'(i); a_wdata = 32'h1000_0000 + 32'(i) * 32'h111;
      @(negedge clk);
    end
    a_addr = 5'd15; a_wdata = 32'h0F0F_0F0F;
    @(negedge clk);
    a_addr = 5'd20; a_wdata = 32'hBAD0_BAD0;
    @(negedge clk);
    idle();
    for (int i = 0; i < 8; i++) begin
      a_req_valid = 1; a_we = 0; a_addr = AW'(7 - i);
      b_req_valid = 1; b_addr = AW'(i);
      @(negedge clk);
    end
    a_addr = 5'd20; b_addr = 5'd15;
    @(negedge clk);
    a_addr = 5'd4; b_addr = 5'd31;
    @(negedge clk);
    idle();
    drain();
  endtask

  task automatic test_reset_midflight();
    int n;
    a_read(5'd3);
    reset = 1;
    a_req_valid = 1; a_we = 1; a_addr = 5'd3; a_wdata = 32'h5555_5555; a_wstrb = 4'hF;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({a_req_ready, b_req_ready, a_resp_valid, b_resp_valid, a_rdata, b_rdata} !== '0) begin
        bad++; $display("FAIL midflight_reset_outputs: got rdy=%b%b vld=%b%b a=%h b=%h, required all 0",
          a_req_ready, b_req_ready, a_resp_valid, b_resp_valid, a_rdata, b_rdata);
      end
    end
    idle();
    release_and_count(n);
    total++;
    if (!a_req_ready) begin bad++; $display("FAIL ready_timeout: got ready=0 after %0d cycles, required 1", n); end
    a_read(5'd3);
    b_read(5'd5);
    drain();
  endtask

`ifdef DP_RAM_CLEAR_EN
  task automatic test_clear();
    int n;
    for (int i = 0; i < DEP; i++) a_write(AW'(i), 32'hC0DE_0000 + 32'(i), 4'hF);
    reset = 1; @(negedge clk);
    release_and_count(n);
    total++;
    if (n != DEP) begin bad++; $display("FAIL clear_len: got %0d, required %0d", n, DEP); end
    for (int i = 0; i < DEP; i++) b_read(AW'(i));
    drain();
    reset = 1; @(negedge clk);
    reset = 0;
    repeat (8) @(negedge clk);
    reset = 1; @(negedge clk);
    release_and_count(n);
    total++;
    if (n != DEP) begin bad++; $display("FAIL clear_restart: got %0d, required %0d", n, DEP); end
  endtask
`endif

  initial begin
    reset = 1; idle();
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_collision();
    test_back_to_back();
    test_reset_midflight();
`ifdef DP_RAM_CLEAR_EN
    test_clear();
`endif
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
